multi_timer: RTL and testbench
==============================

# multi_timer

Parametrised multi-channel timer, successor to the single-channel RTC on the CPU bus. It provides NUM_CHANNELS independent counters, each with a prescaler, period compare, periodic or one-shot mode, and a per-channel IRQ status bit. Counter width is configurable. It sits on the 6502 data bus behind one chip select and drives a single level interrupt.

## Interface
- COUNT_WIDTH, 32: counter, prescaler and period width in bits; multiple of 8, range 8..64.
- NUM_CHANNELS, 4: channel count, range 1..8.
- clk  in  1  system clock; all state updates on the falling edge, matching CPU bus sampling.
- reset  in  1  asynchronous, active-high; clears all state.
- rwb  in  1  1 = read, 0 = write.
- cs  in  1  chip select; asserted for exactly one clk cycle per CPU access.
- addr  in  2  register address.
- i_data  in  8  write data.
- o_data  out  8  read data; combinational from addr and current state.
- irq  out  1  level interrupt, `|(status & irq_en)`.

## Operation
- Definitions: `we = cs & ~rwb`, `re = cs & rwb`, `NB = COUNT_WIDTH/8`.
- addr 0 CHSEL: bits [2:0] select the channel. Reads return CHSEL. A value ≥ NUM_CHANNELS selects nothing: data reads return 0 and data writes are ignored.
- addr 1 CMD:
  - [6:4] selects the register: 0 PRESCALE, 1 PERIOD, 2 COUNT, 3 CTRL.
  - [3:0] is the byte index; index ≥ NB reads 0 and ignores writes.
  - [7] enables auto-increment. Reads return CMD.
- addr 2 DATA: accesses the selected byte of the selected register of the selected channel.
- addr 3 STATUS: bit n = channel n status.
  - Read returns status.
  - Write-1-to-clear.
  - Bits ≥ NUM_CHANNELS read 0.
- Auto-increment: after any addr 2 access with CMD[7]=1, the byte index advances by 1 and wraps from NB-1 to 0.
- CTRL byte 0:
  - bit0 enable.
  - bit1 irq_en.
  - bit2 one_shot.
  - Bits [7:3] read 0. CTRL is single-byte; other byte indices read 0.
- COUNT coherence:
  - A read of COUNT byte 0 latches the full count into a per-channel snapshot, and byte 0 returns the live value.
  - Reads of bytes 1..NB-1 return the snapshot.
- COUNT is writable byte-wise; a write loads that byte of the live count.
- Per-channel counting, only while enabled:
  - pre_cnt increments each cycle.
  - When pre_cnt == PRESCALE, pre_cnt <= 0 and a tick fires.
  - On a tick: if count >= PERIOD, count <= 0, status set, and enable cleared if one_shot; else count <= count+1.
  - The ">=" compare prevents runaway after PERIOD is lowered below the live count.
- Disable holds count and pre_cnt. A CTRL write that changes enable 0→1 clears count and pre_cnt.
- PRESCALE = 0: tick every cycle. PERIOD = 0: status on every tick, count stays 0.
- Arithmetic is unsigned, COUNT_WIDTH bits, modulo 2^COUNT_WIDTH.

## Timing
- Reset values: all registers, snapshots, CHSEL, CMD and status are 0. o_data = 0 (CHSEL read). irq = 0.
- Writes take effect at the falling edge of clk within the cs cycle. Read side effects (snapshot, auto-increment) also occur at that edge.
- o_data is valid combinationally during the cs cycle.
- A tick at edge E sets status at E. irq rises combinationally after E, with no extra latency.
- From enable 0→1 at edge E, the first tick occurs at edge E+PRESCALE+1. Each wrap takes (PERIOD+1)×(PRESCALE+1) cycles.
- Status set and a W1C of the same bit on the same edge: set wins and the bit stays 1.
- Bus write to COUNT coinciding with a tick on the same channel: the bus write wins for the written byte. Other bytes take the tick result.
- A CTRL write with enable=0 on the same edge as a one-shot wrap: the channel ends disabled and status is set.
- Asynchronous reset mid-operation: all state clears immediately and irq drops without waiting for a clock edge.

## Test plan
- Reset: assert reset between edges. Required: irq=0 and o_data=0 immediately, and all registers read 0 afterwards.
- Periodic: ch0 PRESCALE=1, PERIOD=3, CTRL=0x03. Required: status[0] and irq first rise 8 cycles after enable and repeat every 8 cycles. W1C 0x01 drops irq.
- One-shot: ch2 PRESCALE=0, PERIOD=4, CTRL=0x07. Required: status[2] set 5 cycles after enable, then CTRL reads 0x06 and count holds 0.
- Snapshot with auto-increment (COUNT_WIDTH=32): CMD=0xA0, count = 0x000000FF about to roll over. Required: the 4 reads return a coherent value, e.g. FF,00,00,00, never FF,01,00,00.
- Collision: W1C on the same edge as a status set. Required: the bit stays 1. Also lower PERIOD from 10 to 2 while count=7. Required: wrap on the next tick.
- Boundaries: CHSEL=5 with NUM_CHANNELS=4, and a byte index ≥ NB. Required: reads 0, writes ignored, no state change in any channel.

Source files
------------

// File: rtl/multi_timer.sv
// multi_timer: NUM_CHANNELS prescaled period timers behind a byte-wide CPU bus
// window (CHSEL / CMD / DATA / STATUS) with one level interrupt.
module multi_timer #(
  parameter int unsigned COUNT_WIDTH  = 32,
  parameter int unsigned NUM_CHANNELS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rwb,
  input  logic       cs,
  input  logic [1:0] addr,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  output logic       irq
);

  localparam int unsigned CW = COUNT_WIDTH;
  localparam int unsigned NB = COUNT_WIDTH / 8;
  localparam int unsigned NC = NUM_CHANNELS;

  localparam logic [2:0] REG_PRESCALE = 3'd0;
  localparam logic [2:0] REG_PERIOD   = 3'd1;
  localparam logic [2:0] REG_COUNT    = 3'd2;
  localparam logic [2:0] REG_CTRL     = 3'd3;

  typedef logic [CW-1:0] cnt_t;

  logic [7:0]    chsel_q, cmd_q;
  cnt_t          prescale_q [NC];
  cnt_t          period_q   [NC];
  cnt_t          count_q    [NC];
  cnt_t          snap_q     [NC];
  cnt_t          pre_q      [NC];
  cnt_t          prescale_d [NC];
  cnt_t          period_d   [NC];
  cnt_t          count_d    [NC];
  cnt_t          snap_d     [NC];
  cnt_t          pre_d      [NC];
  logic [NC-1:0] en_q, ien_q, os_q, status_q;
  logic [NC-1:0] en_d, ien_d, os_d, status_d;
  logic [NC-1:0] ch_hit, tick, wrap, w1c;

  logic       we, re, data_acc, byte_valid, data_wr, snap_rd;
  logic [2:0] reg_sel;
  logic [3:0] byte_idx, byte_idx_next;
  logic [7:0] data_rd;

  function automatic logic [7:0] get_byte(input cnt_t v, input logic [3:0] idx);
    logic [7:0] r;
    r = '0;
    for (int unsigned b = 0; b < NB; b++)
      if (4'(b) == idx) r = v[b*8 +: 8];
    return r;
  endfunction

  function automatic cnt_t set_byte(input cnt_t v, input logic [3:0] idx, input logic [7:0] d);
    cnt_t r;
    r = v;
    for (int unsigned b = 0; b < NB; b++)
      if (4'(b) == idx) r[b*8 +: 8] = d;
    return r;
  endfunction

  // Bus decode
  assign we            = cs & ~rwb;
  assign re            = cs & rwb;
  assign data_acc      = cs && (addr == 2'd2);
  assign reg_sel       = cmd_q[6:4];
  assign byte_idx      = cmd_q[3:0];
  assign byte_valid    = byte_idx < 4'(NB);
  assign data_wr       = we && (addr == 2'd2) && byte_valid;
  assign snap_rd       = re && (addr == 2'd2) && (reg_sel == REG_COUNT) && (byte_idx == 4'd0);
  assign byte_idx_next = (byte_idx == 4'(NB - 1)) ? 4'd0 : byte_idx + 4'd1;
  assign w1c           = (we && (addr == 2'd3)) ? i_data[NC-1:0] : '0;
  assign irq           = |(status_q & ien_q);

  // Channel select, prescaler tick and period wrap per channel
  always_comb begin
    ch_hit = '0;
    tick   = '0;
    wrap   = '0;
    for (int unsigned c = 0; c < NC; c++) begin
      ch_hit[c] = (chsel_q[2:0] == 3'(c));
      tick[c]   = en_q[c] && (pre_q[c] == prescale_q[c]);
      wrap[c]   = tick[c] && (count_q[c] >= period_q[c]);
    end
  end

  // DATA window read mux; COUNT bytes above 0 come from the coherent snapshot
  always_comb begin
    data_rd = '0;
    for (int unsigned c = 0; c < NC; c++) begin
      if (ch_hit[c]) begin
        case (reg_sel)
          REG_PRESCALE: data_rd = get_byte(prescale_q[c], byte_idx);
          REG_PERIOD:   data_rd = get_byte(period_q[c], byte_idx);
          REG_COUNT:    data_rd = (byte_idx == 4'd0) ? get_byte(count_q[c], 4'd0)
                                                     : get_byte(snap_q[c], byte_idx);
          REG_CTRL:     data_rd = (byte_idx == 4'd0) ? {5'b0, os_q[c], ien_q[c], en_q[c]} : 8'h00;
          default:      data_rd = '0;
        endcase
      end
    end
  end

  // Register file read port
  always_comb begin
    case (addr)
      2'd0:    o_data = chsel_q;
      2'd1:    o_data = cmd_q;
      2'd2:    o_data = data_rd;
      default: o_data = 8'(status_q);
    endcase
  end

  // Next channel state: counting first, then bus writes override their fields
  always_comb begin
    prescale_d = prescale_q;
    period_d   = period_q;
    count_d    = count_q;
    snap_d     = snap_q;
    pre_d      = pre_q;
    en_d       = en_q;
    ien_d      = ien_q;
    os_d       = os_q;
    status_d   = (status_q & ~w1c) | wrap;
    for (int unsigned c = 0; c < NC; c++) begin
      if (en_q[c]) begin
        if (tick[c]) begin
          pre_d[c] = '0;
          if (wrap[c]) begin
            count_d[c] = '0;
            if (os_q[c]) en_d[c] = 1'b0;
          end else begin
            count_d[c] = count_q[c] + cnt_t'(1);
          end
        end else begin
          pre_d[c] = pre_q[c] + cnt_t'(1);
        end
      end
      if (snap_rd && ch_hit[c]) snap_d[c] = count_q[c];
      if (data_wr && ch_hit[c]) begin
        case (reg_sel)
          REG_PRESCALE: prescale_d[c] = set_byte(prescale_q[c], byte_idx, i_data);
          REG_PERIOD:   period_d[c]   = set_byte(period_q[c], byte_idx, i_data);
          REG_COUNT:    count_d[c]    = set_byte(count_d[c], byte_idx, i_data);
          REG_CTRL: begin
            if (byte_idx == 4'd0) begin
              en_d[c]  = i_data[0];
              ien_d[c] = i_data[1];
              os_d[c]  = i_data[2];
              if (!en_q[c] && i_data[0]) begin
                count_d[c] = '0;
                pre_d[c]   = '0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // State registers, updated on the falling edge with the CPU bus
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      chsel_q  <= '0;
      cmd_q    <= '0;
      en_q     <= '0;
      ien_q    <= '0;
      os_q     <= '0;
      status_q <= '0;
      for (int unsigned c = 0; c < NC; c++) begin
        prescale_q[c] <= '0;
        period_q[c]   <= '0;
        count_q[c]    <= '0;
        snap_q[c]     <= '0;
        pre_q[c]      <= '0;
      end
    end else begin
      if (we && (addr == 2'd0)) chsel_q <= i_data;
      if (we && (addr == 2'd1)) cmd_q <= i_data;
      else if (data_acc && cmd_q[7]) cmd_q[3:0] <= byte_idx_next;
      en_q     <= en_d;
      ien_q    <= ien_d;
      os_q     <= os_d;
      status_q <= status_d;
      for (int unsigned c = 0; c < NC; c++) begin
        prescale_q[c] <= prescale_d[c];
        period_q[c]   <= period_d[c];
        count_q[c]    <= count_d[c];
        snap_q[c]     <= snap_d[c];
        pre_q[c]      <= pre_d[c];
      end
    end
  end

endmodule

// File: tb/tb_multi_timer.sv
// Bench for multi_timer: directed scenarios plus random bus traffic, compared
// against a transaction-level model of the timer register map.
module tb_multi_timer;

  localparam int CW = 32;
  localparam int NC = 4;
  localparam int NB = CW / 8;
  localparam longint unsigned MASK = 64'hFFFF_FFFF;

  logic       clk, reset, rwb, cs, irq;
  logic [1:0] addr;
  logic [7:0] i_data, o_data;

  int checks = 0;
  int errors = 0;

  // Reference model state
  longint unsigned m_ps [NC];
  longint unsigned m_per[NC];
  longint unsigned m_cnt[NC];
  longint unsigned m_pc [NC];
  longint unsigned m_snap[NC];
  bit m_en[NC], m_ie[NC], m_os[NC], m_st[NC];
  bit [7:0] m_chsel, m_cmd;

  multi_timer #(.COUNT_WIDTH(CW), .NUM_CHANNELS(NC)) dut (
    .clk(clk), .reset(reset), .rwb(rwb), .cs(cs), .addr(addr),
    .i_data(i_data), .o_data(o_data), .irq(irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic bit [7:0] byte_of(input longint unsigned v, input int i);
    return 8'(v >> (8 * i));
  endfunction

  function automatic longint unsigned put_byte(input longint unsigned v, input int i, input bit [7:0] d);
    return (v & ~(64'hFF << (8 * i))) | (64'(d) << (8 * i));
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NC; c++) begin
      m_ps[c] = 0; m_per[c] = 0; m_cnt[c] = 0; m_pc[c] = 0; m_snap[c] = 0;
      m_en[c] = 0; m_ie[c] = 0; m_os[c] = 0; m_st[c] = 0;
    end
    m_chsel = 0;
    m_cmd   = 0;
  endfunction

  function automatic bit model_irq();
    for (int c = 0; c < NC; c++)
      if (m_st[c] && m_ie[c]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit [7:0] model_read(input bit [1:0] a);
    int ch = int'(m_chsel[2:0]);
    int rg = int'(m_cmd[6:4]);
    int ix = int'(m_cmd[3:0]);
    bit [7:0] st = 8'h00;
    case (a)
      2'd0: return m_chsel;
      2'd1: return m_cmd;
      2'd3: begin
        for (int c = 0; c < NC; c++) st[c] = m_st[c];
        return st;
      end
      default: begin
        if (ch >= NC || ix >= NB) return 8'h00;
        case (rg)
          0: return byte_of(m_ps[ch], ix);
          1: return byte_of(m_per[ch], ix);
          2: return (ix == 0) ? byte_of(m_cnt[ch], 0) : byte_of(m_snap[ch], ix);
          3: return (ix == 0) ? {5'b0, m_os[ch], m_ie[ch], m_en[ch]} : 8'h00;
          default: return 8'h00;
        endcase
      end
    endcase
  endfunction

  // One falling edge: read effects and W1C see the old state, ticks run,
  // then bus writes overwrite the fields they touch.
  function automatic void model_step(input bit acc, input bit r, input bit [1:0] a, input bit [7:0] d);
    int ch = int'(m_chsel[2:0]);
    int rg = int'(m_cmd[6:4]);
    int ix = int'(m_cmd[3:0]);
    bit chv = ch < NC;
    bit was_en = chv ? m_en[ch] : 1'b0;
    if (acc && r && a == 2 && chv && rg == 2 && ix == 0) m_snap[ch] = m_cnt[ch];
    if (acc && !r && a == 3)
      for (int c = 0; c < NC; c++) if (d[c]) m_st[c] = 1'b0;
    for (int c = 0; c < NC; c++) begin
      if (!m_en[c]) continue;
      if (m_pc[c] != m_ps[c]) begin
        m_pc[c] = (m_pc[c] + 1) & MASK;
      end else begin
        m_pc[c] = 0;
        if (m_cnt[c] >= m_per[c]) begin
          m_cnt[c] = 0;
          m_st[c]  = 1'b1;
          if (m_os[c]) m_en[c] = 1'b0;
        end else begin
          m_cnt[c] = (m_cnt[c] + 1) & MASK;
        end
      end
    end
    if (acc && !r && a == 2 && chv && ix < NB) begin
      case (rg)
        0: m_ps[ch]  = put_byte(m_ps[ch], ix, d);
        1: m_per[ch] = put_byte(m_per[ch], ix, d);
        2: m_cnt[ch] = put_byte(m_cnt[ch], ix, d);
        3: if (ix == 0) begin
          if (!was_en && d[0]) begin
            m_cnt[ch] = 0;
            m_pc[ch]  = 0;
          end
          m_en[ch] = d[0];
          m_ie[ch] = d[1];
          m_os[ch] = d[2];
        end
        default: ;
      endcase
    end
    if (acc && !r && a == 0) m_chsel = d;
    if (acc && !r && a == 1) m_cmd = d;
    else if (acc && a == 2 && m_cmd[7])
      m_cmd[3:0] = (ix == NB - 1) ? 4'd0 : 4'(ix + 1);
  endfunction

  task automatic bus(input bit r, input bit [1:0] a, input bit [7:0] d, output bit [7:0] q);
    bit [7:0] expv;
    @(posedge clk);
    cs = 1'b1; rwb = r; addr = a; i_data = d;
    #2;
    q = o_data;
    if (r) begin
      expv = model_read(a);
      check($sformatf("read addr%0d", a), 64'(o_data), 64'(expv));
    end
    @(negedge clk);
    model_step(1'b1, r, a, d);
    #1;
    cs = 1'b0; rwb = 1'b1;
    check("irq after access", 64'(irq), 64'(model_irq()));
  endtask

  task automatic wr(input bit [1:0] a, input bit [7:0] d);
    bit [7:0] dummy;
    bus(1'b0, a, d, dummy);
  endtask

  task automatic rd(input bit [1:0] a, output bit [7:0] q);
    bus(1'b1, a, 8'h00, q);
  endtask

  task automatic idle(output bit v);
    @(posedge clk);
    @(negedge clk);
    model_step(1'b0, 1'b1, 2'd0, 8'h00);
    #1;
    v = irq;
    check("irq idle", 64'(irq), 64'(model_irq()));
  endtask

  task automatic set_reg(input int ch, input int rg, input longint unsigned val);
    wr(2'd0, 8'(ch));
    wr(2'd1, {1'b1, 3'(rg), 4'd0});
    for (int b = 0; b < NB; b++) wr(2'd2, byte_of(val, b));
  endtask

  task automatic sweep(input bit zero);
    bit [7:0] q;
    for (int ch = 0; ch < NC; ch++)
      for (int rg = 0; rg < 4; rg++)
        for (int b = 0; b < NB; b++) begin
          wr(2'd0, 8'(ch));
          wr(2'd1, {1'b0, 3'(rg), 4'(b)});
          rd(2'd2, q);
          if (zero) check("register zero after reset", 64'(q), 64'h0);
        end
    rd(2'd3, q);
    if (zero) check("status zero after reset", 64'(q), 64'h0);
  endtask

  initial begin
    bit [7:0] q, d;
    bit v;
    bit [1:0] a;
    int sel;

    reset = 1'b1; cs = 1'b0; rwb = 1'b1; addr = 2'd0; i_data = 8'h00;
    model_reset();
    #12;
    check("reset o_data", 64'(o_data), 64'h0);
    check("reset irq", 64'(irq), 64'h0);
    #10 reset = 1'b0;
    sweep(1'b1);

    // Periodic channel 0: prescale 1, period 3 -> 8-cycle wrap
    set_reg(0, 0, 1);
    set_reg(0, 1, 3);
    wr(2'd1, 8'h30);
    wr(2'd2, 8'h03);
    for (int k = 1; k <= 8; k++) begin
      idle(v);
      check($sformatf("periodic first rise k=%0d", k), 64'(v), 64'(k == 8));
    end
    wr(2'd3, 8'h01);
    check("w1c drops irq", 64'(irq), 64'h0);
    for (int k = 2; k <= 8; k++) begin
      idle(v);
      check($sformatf("periodic repeat k=%0d", k), 64'(v), 64'(k == 8));
    end
    wr(2'd1, 8'h30);
    wr(2'd2, 8'h00);
    wr(2'd3, 8'hFF);

    // One-shot channel 2: prescale 0, period 4
    set_reg(2, 0, 0);
    set_reg(2, 1, 4);
    wr(2'd1, 8'h30);
    wr(2'd2, 8'h07);
    for (int k = 1; k <= 5; k++) begin
      idle(v);
      check($sformatf("oneshot k=%0d", k), 64'(v), 64'(k == 5));
    end
    rd(2'd2, q);
    check("oneshot ctrl", 64'(q), 64'h06);
    wr(2'd1, 8'h20);
    rd(2'd2, q);
    check("oneshot count", 64'(q), 64'h0);
    for (int k = 0; k < 3; k++) idle(v);
    rd(2'd2, q);
    check("oneshot count holds", 64'(q), 64'h0);
    wr(2'd3, 8'h04);
    check("oneshot w1c", 64'(irq), 64'h0);
    wr(2'd1, 8'h30);
    wr(2'd2, 8'h00);

    // Coherent COUNT read across the 0xFF -> 0x100 carry
    set_reg(1, 1, 64'hFFFF_FFFF);
    wr(2'd1, 8'h30);
    wr(2'd2, 8'h01);
    wr(2'd1, 8'h20);
    wr(2'd2, 8'hFE);
    wr(2'd1, 8'hA0);
    for (int b = 0; b < NB; b++) begin
      rd(2'd2, q);
      check($sformatf("snapshot byte%0d", b), 64'(q), 64'((b == 0) ? 8'hFF : 8'h00));
    end
    wr(2'd1, 8'h30);
    wr(2'd2, 8'h00);

    // W1C on the same edge as a status set on channel 3
    set_reg(3, 0, 0);
    set_reg(3, 1, 2);
    wr(2'd1, 8'h30);
    wr(2'd2, 8'h03);
    for (int k = 1; k <= 5; k++) begin
      idle(v);
      check($sformatf("collision pre k=%0d", k), 64'(v), 64'(k >= 3));
    end
    wr(2'd3, 8'h08);
    check("set beats w1c irq", 64'(irq), 64'h1);
    rd(2'd3, q);
    check("set beats w1c status", 64'(q[3]), 64'h1);
    wr(2'd3, 8'h08);
    check("plain w1c", 64'(irq), 64'h0);
    wr(2'd1, 8'h30);
    wr(2'd2, 8'h00);
    wr(2'd3, 8'hFF);

    // Lower PERIOD below the live count: wrap on the next tick
    set_reg(0, 0, 0);
    set_reg(0, 1, 10);
    wr(2'd1, 8'h30);
    wr(2'd2, 8'h03);
    wr(2'd1, 8'h10);
    for (int k = 0; k < 5; k++) idle(v);
    wr(2'd2, 8'h02);
    check("no wrap at count 7", 64'(irq), 64'h0);
    idle(v);
    check("wrap after period lowered", 64'(v), 64'h1);
    wr(2'd1, 8'h20);
    rd(2'd2, q);
    check("count restarted", 64'(q), 64'h1);
    wr(2'd1, 8'h30);
    wr(2'd2, 8'h00);
    wr(2'd3, 8'hFF);

    // Out-of-range channel and byte index
    wr(2'd0, 8'h05);
    wr(2'd1, 8'h10);
    rd(2'd2, q);
    check("chsel 5 read", 64'(q), 64'h0);
    wr(2'd2, 8'hAA);
    wr(2'd1, 8'h30);
    wr(2'd2, 8'h03);
    rd(2'd0, q);
    check("chsel readback", 64'(q), 64'h05);
    wr(2'd0, 8'h00);
    wr(2'd1, 8'h15);
    rd(2'd2, q);
    check("byte index 5 read", 64'(q), 64'h0);
    wr(2'd2, 8'h55);
    wr(2'd1, 8'h34);
    wr(2'd2, 8'h07);
    wr(2'd1, 8'h30);
    rd(2'd2, q);
    check("ch0 ctrl untouched", 64'(q), 64'h0);
    wr(2'd1, 8'h10);
    rd(2'd2, q);
    check("ch0 period untouched", 64'(q), 64'h02);
    sweep(1'b0);

    // Random traffic against the model
    for (int c = 0; c < NC; c++) begin
      set_reg(c, 0, longint'($urandom_range(0, 3)));
      set_reg(c, 1, longint'($urandom_range(0, 6)));
      wr(2'd1, 8'h30);
      wr(2'd2, 8'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 2) begin
        idle(v);
      end else begin
        a = 2'($urandom_range(0, 3));
        case (a)
          2'd0: d = (sel == 9) ? 8'($urandom) : 8'($urandom_range(0, 7));
          2'd1: d = {1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), 4'($urandom_range(0, 4))};
          2'd2: d = 8'($urandom_range(0, 7));
          default: d = 8'($urandom);
        endcase
        bus(1'($urandom_range(0, 1)), a, d, q);
      end
    end
    sweep(1'b0);

    // Asynchronous reset while irq is high
    wr(2'd3, 8'hFF);
    set_reg(0, 0, 0);
    set_reg(0, 1, 0);
    wr(2'd1, 8'h30);
    wr(2'd2, 8'h00);
    wr(2'd2, 8'h03);
    idle(v);
    check("irq before reset", 64'(v), 64'h1);
    @(posedge clk);
    addr = 2'd0;
    #2 reset = 1'b1;
    #1;
    check("async reset irq", 64'(irq), 64'h0);
    check("async reset o_data", 64'(o_data), 64'h0);
    model_reset();
    #4 reset = 1'b0;
    sweep(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
